// File: rtl/tlp_req_arbiter.sv
// rtl/tlp_req_arbiter.sv - round-robin sharing of the endpoint TLP request channel
module tlp_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_hdr,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic [31:0]       tlpd,
  output logic              tlpd_valid,
  input  logic [31:0]       tlpr,
  input  logic              tlpr_valid,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  logic [2:0]      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;
  logic [CW-1:0]   wait_cnt;

  logic [IW-1:0]   win;
  logic            win_found;
  logic [IW-1:0]   win_next;
  logic [NREQ-1:0] owner_oh;
  int              idx;

  // First requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win       = IW'(idx);
      end
    end
  end

  assign win_next = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wait_cnt    <= '0;
      req_ack     <= '0;
      tlpd        <= '0;
      tlpd_valid  <= 1'b0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      req_ack     <= '0;
      rsp_valid   <= '0;
      rsp_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            owner          <= win;
            addr_q         <= req_addr[32*win +: 32];
            data_q         <= req_data[32*win +: 32];
            req_ack        <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            tlpd           <= req_hdr[32*win +: 32];
            tlpd_valid     <= 1'b1;
            busy           <= 1'b1;
            rr_ptr         <= win_next;
            state          <= S_HDR;
          end
        end
        S_HDR: begin
          tlpd  <= addr_q;
          state <= S_ADDR;
        end
        S_ADDR: begin
          tlpd  <= data_q;
          state <= S_DATA;
        end
        S_DATA: begin
          tlpd       <= '0;
          tlpd_valid <= 1'b0;
          wait_cnt   <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (tlpr_valid) begin
            rsp_data  <= tlpr;
            rsp_valid <= owner_oh;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (wait_cnt == TMAX) begin
            rsp_data    <= 32'hDEAD_BEEF;
            rsp_valid   <= owner_oh;
            rsp_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          tlpd       <= '0;
          tlpd_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
